// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage: turns one load/store per instruction into a dmem req/ready transaction.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        bus_err,
   output logic        misalign,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata
);

   localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         f3_q, f3_d;
   logic [1:0]         off_q, off_d;
   logic               req_q, req_d, we_q, we_d;
   logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]         be_q, be_d;
   logic               done_q, done_d, err_q, err_d, mis_q, mis_d;
   logic               stall_c;

   logic               op_c, is_b_c, is_h_c, mis_c;
   logic [3:0]         be_c;
   logic [31:0]        wd_c, fmt_c;
   logic [7:0]         byte_c;
   logic [15:0]        half_c;

   // Access size decode and store lane placement from the live instruction
   always_comb begin
      op_c   = mem_read | mem_write;
      is_b_c = (funct3 == 3'b000) || (funct3 == 3'b100);
      is_h_c = (funct3 == 3'b001) || (funct3 == 3'b101);
      if (is_b_c) begin
         be_c = 4'b0001 << addr[1:0];
         wd_c = {4{wdata[7:0]}};
      end else if (is_h_c) begin
         be_c = 4'b0011 << {addr[1], 1'b0};
         wd_c = {2{wdata[15:0]}};
      end else begin
         be_c = 4'b1111;
         wd_c = wdata;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      mis_c = (is_h_c && addr[0]) || (!is_b_c && !is_h_c && (addr[1:0] != 2'b00));
`else
      mis_c = 1'b0;
`endif
   end

   // Load extraction and extension using the latched funct3/offset
   always_comb begin
      byte_c = 8'(dmem_rdata >> {off_q, 3'b000});
      half_c = 16'(dmem_rdata >> {off_q[1], 4'b0000});
      case (f3_q)
         3'b000:  fmt_c = {{24{byte_c[7]}}, byte_c};
         3'b100:  fmt_c = {24'd0, byte_c};
         3'b001:  fmt_c = {{16{half_c[15]}}, half_c};
         3'b101:  fmt_c = {16'd0, half_c};
         default: fmt_c = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      off_d   = off_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      mis_d   = 1'b0;
      stall_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_c && mis_c) begin
               done_d  = 1'b1;
               mis_d   = 1'b1;
               rdata_d = 32'd0;
            end else if (op_c) begin
               stall_c = 1'b1;
               state_d = REQ;
               req_d   = 1'b1;
               we_d    = mem_write;
               addr_d  = {addr[31:2], 2'b00};
               be_d    = be_c;
               wdata_d = wd_c;
               f3_d    = funct3;
               off_d   = addr[1:0];
               cnt_d   = '0;
            end
         end
         REQ: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (dmem_ready) begin
               state_d = DONE;
               req_d   = 1'b0;
               done_d  = 1'b1;
               rdata_d = we_q ? 32'd0 : fmt_c;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_LAST))) begin
               state_d = DONE;
               req_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   // Stall is forced low while reset is held so the core is released immediately
   assign stall      = stall_c & rst_n;
   assign done       = done_q;
   assign rdata      = rdata_q;
   assign bus_err    = err_q;
   assign misalign   = mis_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus randomized accesses against a transaction model.
module tb_lsu_mem_stage;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall, done, bus_err, misalign;
   logic [31:0] rdata;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   lsu_mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
      .rdata(rdata), .bus_err(bus_err), .misalign(misalign), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // expectations for the per-cycle compare process
   bit          chk_en = 0;
   logic        e_stall = 0, e_done = 0, e_req = 0, e_err = 0;
   bit          fld = 0, chk_be = 0, chk_wd = 0, chk_rd = 0;
   logic        e_we = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;
   logic [3:0]  e_be = 0;

   // values captured from the last transaction for literal checks
   logic [31:0] cap_addr, cap_wd, cap_rdata;
   logic [3:0]  cap_be;
   logic        cap_we, cap_err;
   int          req_cnt;

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic int unsigned size_of(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ld_model(input logic [2:0] f3, input int unsigned off, input logic [31:0] w);
      int unsigned b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
         3'd4:    return 32'(b);
         3'd1:    return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
         3'd5:    return 32'(h);
         default: return w;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("stall", 32'(stall), 32'(e_stall));
         check("done", 32'(done), 32'(e_done));
         check("dmem_req", 32'(dmem_req), 32'(e_req));
         check("bus_err", 32'(bus_err), 32'(e_err));
         check("misalign", 32'(misalign), 32'd0);
         if (fld) begin
            check("dmem_addr", dmem_addr, e_addr);
            check("dmem_we", 32'(dmem_we), 32'(e_we));
         end
         if (chk_be) check("dmem_be", 32'(dmem_be), 32'(e_be));
         if (chk_wd) check("dmem_wdata", dmem_wdata, e_wdata);
         if (chk_rd) check("rdata", rdata, e_rdata);
      end
   end

   // One instruction; entered and left at posedge+1. wait_n = REQ cycles before ready.
   task automatic access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int wait_n, input logic [31:0] rw);
      int unsigned n, off, start;
      int k;
      bit tmo;
      logic [31:0] rep;
      n     = size_of(f3);
      off   = 32'(a[1:0]);
      start = off - (off % n);
      rep   = 32'd0;
      for (int i = 0; i < 4; i++) rep[8*i +: 8] = 8'(wd >> (8 * (i % int'(n))));
      mem_write = wr; mem_read = !wr; funct3 = f3; addr = a; wdata = wd;
      dmem_ready = 1'b0; dmem_rdata = $urandom;
      e_stall = 1; e_req = 0; e_done = 0; e_err = 0;
      fld = 0; chk_be = 0; chk_wd = 0; chk_rd = 0;
      @(posedge clk); #1;
      e_req = 1; fld = 1;
      e_addr = a & 32'hFFFF_FFFC; e_we = wr;
      e_be = 4'(((1 << n) - 1) << start); chk_be = wr || (n == 4);
      e_wdata = rep; chk_wd = wr;
      k = 0; tmo = 0; req_cnt = 0;
      forever begin
         dmem_ready = (k == wait_n);
         dmem_rdata = dmem_ready ? rw : $urandom;
         @(negedge clk);
         cap_addr = dmem_addr; cap_be = dmem_be; cap_wd = dmem_wdata; cap_we = dmem_we;
         if (dmem_req) req_cnt++;
         @(posedge clk); #1;
         if (k == wait_n) break;
         if (k == int'(TO) - 1) begin tmo = 1; break; end
         k++;
      end
      dmem_ready = 1'b0; dmem_rdata = $urandom;
      e_stall = 0; e_req = 0; e_done = 1; e_err = tmo;
      fld = 0; chk_be = 0; chk_wd = 0;
      chk_rd = !wr; e_rdata = tmo ? 32'd0 : ld_model(f3, off, rw);
      @(negedge clk);
      cap_rdata = rdata; cap_err = bus_err;
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
      e_done = 0; e_err = 0; e_stall = 0; chk_rd = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] f3;
      bit wr;
      int w;
      rst_n = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
      dmem_ready = 0; dmem_rdata = 0;
      #12;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_be", 32'(dmem_be), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      chk_en = 1;
      @(posedge clk); #1;

      access(0, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF);
      check("lw_rdata", cap_rdata, 32'hDEADBEEF);
      check("lw_addr", cap_addr, 32'h100);
      check("lw_be", 32'(cap_be), 32'hF);

      access(0, 3'b000, 32'h103, 32'd0, 1, 32'h80112233);
      check("lb_rdata", cap_rdata, 32'hFFFFFF80);
      access(0, 3'b100, 32'h103, 32'd0, 0, 32'h80112233);
      check("lbu_rdata", cap_rdata, 32'h00000080);

      access(1, 3'b000, 32'h102, 32'h000000A5, 0, 32'd0);
      check("sb_be", 32'(cap_be), 32'h4);
      check("sb_wdata", cap_wd, 32'hA5A5A5A5);
      check("sb_we", 32'(cap_we), 32'd1);
      access(1, 3'b001, 32'h102, 32'h00001234, 2, 32'd0);
      check("sh_be", 32'(cap_be), 32'hC);
      check("sh_wdata", cap_wd, 32'h12341234);

      access(0, 3'b010, 32'h40, 32'd0, 100, 32'h12345678);
      check("to_err", 32'(cap_err), 32'd1);
      check("to_rdata", cap_rdata, 32'd0);
      check("to_req_cycles", 32'(req_cnt), 32'd16);

      // reset asserted mid-REQ with ready low
      chk_en = 0;
      mem_read = 1; funct3 = 3'b010; addr = 32'h200; dmem_ready = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_req_before_rst", 32'(dmem_req), 32'd1);
      #2 rst_n = 0;
      #1;
      check("rst_drops_req", 32'(dmem_req), 32'd0);
      check("rst_drops_stall", 32'(stall), 32'd0);
      mem_read = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      chk_en = 1;
      access(0, 3'b010, 32'h300, 32'd0, 1, 32'hCAFEF00D);
      check("post_rst_lw", cap_rdata, 32'hCAFEF00D);

      access(0, 3'b010, 32'h101, 32'd0, 0, 32'h0BADF00D);
      check("mis_lw_addr", cap_addr, 32'h100);
      check("mis_lw_be", 32'(cap_be), 32'hF);
      check("mis_lw_rdata", cap_rdata, 32'h0BADF00D);

      for (int t = 0; t < 80; t++) begin
         wr = 1'($urandom_range(0, 1));
         if (wr) f3 = 3'($urandom_range(0, 2));
         else    f3 = 3'($urandom_range(0, 7));
         w = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
         access(wr, f3, $urandom, $urandom, w, $urandom);
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
      end

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
